// File: rtl/fu_pkg.sv
// rtl/fu_pkg.sv - shared encodings, state codes and latency defaults for the FU issue controller
package fu_pkg;

  localparam logic [1:0] CLS_ALU   = 2'd0;
  localparam logic [1:0] CLS_SHIFT = 2'd1;
  localparam logic [1:0] CLS_MADD  = 2'd2;
  localparam logic [1:0] CLS_ILL   = 2'd3;

  localparam int EN_ALU  = 2;
  localparam int EN_BS   = 1;
  localparam int EN_MADD = 0;

  typedef logic [1:0] fu_state_t;
  localparam fu_state_t ST_IDLE = 2'd0;
  localparam fu_state_t ST_EXEC = 2'd1;
  localparam fu_state_t ST_CAPT = 2'd2;
  localparam fu_state_t ST_RESP = 2'd3;

  localparam int DEF_MADD_LAT = 3;
  localparam int DEF_ALU_LAT  = 1;
  localparam int DEF_BS_LAT   = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One-hot sub-unit enable for a legal class; illegal class never enables anything.
  function automatic logic [2:0] cls_en(input logic [1:0] cls);
    logic [2:0] en;
    en = 3'b000;
    case (cls)
      CLS_ALU:   en[EN_ALU]  = 1'b1;
      CLS_SHIFT: en[EN_BS]   = 1'b1;
      CLS_MADD:  en[EN_MADD] = 1'b1;
      default:   en = 3'b000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; pointer moves past the winner on each accepted grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       pri
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = pri ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pri <= 1'b0;
    end else if (advance) begin
      pri <= gnt[0];
    end
  end

endmodule

// File: rtl/fu_issue_ctrl.sv
// rtl/fu_issue_ctrl.sv - shares a non-pipelined ALU/shifter/MADD unit between two requesters
module fu_issue_ctrl
  import fu_pkg::*;
#(
  parameter int MADD_LAT = DEF_MADD_LAT,
  parameter int ALU_LAT  = DEF_ALU_LAT,
  parameter int BS_LAT   = DEF_BS_LAT
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [1:0]  REQ_VALID,
  output logic [1:0]  REQ_READY,
  input  logic [1:0]  REQ0_CLASS,
  input  logic [1:0]  REQ1_CLASS,
  input  logic [3:0]  REQ0_OP,
  input  logic [3:0]  REQ1_OP,
  input  logic [31:0] REQ0_A,
  input  logic [31:0] REQ0_B,
  input  logic [31:0] REQ0_C,
  input  logic [31:0] REQ1_A,
  input  logic [31:0] REQ1_B,
  input  logic [31:0] REQ1_C,
  output logic [2:0]  FU_EN,
  output logic [3:0]  FU_OP,
  output logic [31:0] FU_A,
  output logic [31:0] FU_B,
  output logic [31:0] FU_C,
  input  logic [31:0] FU_Z,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic        RES_TAG,
  output logic        RES_ERR,
  output logic [31:0] RES_DATA
);

  localparam int MAX_LAT = max3(MADD_LAT, ALU_LAT, BS_LAT);
  localparam int CW      = $clog2(MAX_LAT) + 1;

  fu_state_t     state;
  logic [CW-1:0] cnt;
  logic [1:0]    gnt;
  logic          pri;
  logic          hs;
  logic          win_id;
  logic [1:0]    win_cls;
  logic [3:0]    win_op;
  logic [31:0]   win_a, win_b, win_c;

  function automatic logic [CW-1:0] cls_lat(input logic [1:0] cls);
    logic [CW-1:0] l;
    l = '0;
    case (cls)
      CLS_ALU:   l = CW'(ALU_LAT);
      CLS_SHIFT: l = CW'(BS_LAT);
      CLS_MADD:  l = CW'(MADD_LAT);
      default:   l = '0;
    endcase
    return l;
  endfunction

  rr_arb2 u_arb (
    .clk     (CLOCK),
    .rst     (RESET),
    .req     (REQ_VALID),
    .advance (hs),
    .gnt     (gnt),
    .pri     (pri)
  );

  assign REQ_READY = (state == ST_IDLE && !RESET) ? gnt : 2'b00;
  assign hs        = |(REQ_VALID & REQ_READY);
  assign RES_VALID = (state == ST_RESP);

  assign win_id  = gnt[1];
  assign win_cls = win_id ? REQ1_CLASS : REQ0_CLASS;
  assign win_op  = win_id ? REQ1_OP    : REQ0_OP;
  assign win_a   = win_id ? REQ1_A     : REQ0_A;
  assign win_b   = win_id ? REQ1_B     : REQ0_B;
  assign win_c   = win_id ? REQ1_C     : REQ0_C;

  // FU_EN is a plain flop loaded on entry to and exit from EXEC so the unit's clock gates never glitch.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      FU_EN    <= 3'b000;
      FU_OP    <= 4'h0;
      FU_A     <= 32'h0;
      FU_B     <= 32'h0;
      FU_C     <= 32'h0;
      RES_TAG  <= 1'b0;
      RES_ERR  <= 1'b0;
      RES_DATA <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs) begin
            FU_OP   <= win_op;
            FU_A    <= win_a;
            FU_B    <= win_b;
            FU_C    <= win_c;
            RES_TAG <= win_id;
            cnt     <= cls_lat(win_cls);
            if (win_cls == CLS_ILL) begin
              RES_ERR  <= 1'b1;
              RES_DATA <= 32'h0;
              state    <= ST_RESP;
            end else begin
              FU_EN <= cls_en(win_cls);
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            FU_EN <= 3'b000;
            state <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          RES_DATA <= FU_Z;
          RES_ERR  <= 1'b0;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (RES_READY) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
